// File: rtl/mmu_arbiter.sv
// Shares the single-port MMU between buffered sampler writes and host reads.
// At most one MMU strobe per cycle; reads yield to writes when the FIFO is near full.
module mmu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             smpl_valid_i,
  input  logic [WIDTH-1:0] smpl_i,
  input  logic             rd_req_i,
  output logic             rd_ack_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             mem_wrt_o,
  output logic             mem_read_o,
  output logic [WIDTH-1:0] mem_o,
  input  logic [WIDTH-1:0] mem_i,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [WIDTH-1:0] r_buf [WBUF_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_state;
  logic [LW-1:0]    r_lat;

  logic w_push;
  logic w_rd_grant;
  logic w_wr_grant;

  // Read handshake is 4-phase: rd_req_i stays high until rd_ack_o pulses, then
  // drops; a new read is only granted once the FSM has seen the drop in HOLD.
  // A read is granted only while at least two FIFO slots remain free, so a
  // sample arriving every cycle can never overflow the buffer.
  assign w_push     = smpl_valid_i;
  assign w_rd_grant = (r_state == S_IDLE) && rd_req_i &&
                      (r_count < CW'(WBUF_DEPTH - 1));
  assign w_wr_grant = !w_rd_grant && (r_count != '0);

  assign busy_o      = (r_count != '0) || (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf[r_wptr] <= smpl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      mem_wrt_o <= 1'b0;
      mem_o     <= '0;
    end else begin
      mem_wrt_o <= w_wr_grant;
      if (w_wr_grant) begin
        mem_o  <= r_buf[r_rptr];
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      case ({w_push, w_wr_grant})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_lat      <= '0;
      rd_ack_o   <= 1'b0;
      rd_data_o  <= '0;
      mem_read_o <= 1'b0;
    end else begin
      mem_read_o <= w_rd_grant;
      rd_ack_o   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rd_grant) begin
            r_lat   <= LW'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter reaches zero RD_LAT edges after the strobe; mem_i is valid then.
          if (r_lat == '0) begin
            rd_data_o <= mem_i;
            rd_ack_o  <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_HOLD: begin
          if (!rd_req_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_wr_grant && (r_count == CW'(WBUF_DEPTH))));

  a_one_strobe: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_wrt_o && mem_read_o));

endmodule

// File: tb/tb_mmu_arbiter.sv
// Bench for mmu_arbiter: two instances (RD_LAT=1 and RD_LAT=4) share the sample
// stream and are each checked every cycle against a queue-based reference model.
module tb_mmu_arbiter;

  localparam int W = 32;
  localparam int D = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i;
  logic         smpl_valid;
  logic [W-1:0] smpl;
  logic [1:0]   man_req;
  logic [1:0]   auto_req = '0;
  logic         req_mode;
  logic [1:0]   rd_req;
  logic [1:0]   rd_ack, mem_wrt, mem_read, busy;
  logic [W-1:0] rd_data [2];
  logic [W-1:0] mem_o   [2];
  logic [W-1:0] mem_i   [2];
  logic [1:0]   dbg_l1, dbg_l4;

  assign rd_req = req_mode ? auto_req : man_req;

  mmu_arbiter #(.WIDTH(W), .WBUF_DEPTH(D), .RD_LAT(1)) u_dut_l1 (
    .clk_i(clk), .rst_i(rst_i), .smpl_valid_i(smpl_valid), .smpl_i(smpl),
    .rd_req_i(rd_req[0]), .rd_ack_o(rd_ack[0]), .rd_data_o(rd_data[0]),
    .mem_wrt_o(mem_wrt[0]), .mem_read_o(mem_read[0]), .mem_o(mem_o[0]),
    .mem_i(mem_i[0]), .busy_o(busy[0]), .dbg_state_o(dbg_l1)
  );

  mmu_arbiter #(.WIDTH(W), .WBUF_DEPTH(D), .RD_LAT(4)) u_dut_l4 (
    .clk_i(clk), .rst_i(rst_i), .smpl_valid_i(smpl_valid), .smpl_i(smpl),
    .rd_req_i(rd_req[1]), .rd_ack_o(rd_ack[1]), .rd_data_o(rd_data[1]),
    .mem_wrt_o(mem_wrt[1]), .mem_read_o(mem_read[1]), .mem_o(mem_o[1]),
    .mem_i(mem_i[1]), .busy_o(busy[1]), .dbg_state_o(dbg_l4)
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // scoreboard state
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: exp_q holds every accepted sample in push order; each
  // instance drains it through its own index, so the FIFO count is simply
  // pushed-minus-written. A read is a countdown to a target edge number.
  logic [W-1:0] exp_q [$];
  int           wr_idx [2] = '{0, 0};
  bit           rd_act [2] = '{1'b0, 1'b0};
  bit           rd_hold[2] = '{1'b0, 1'b0};
  int           tgt    [2] = '{0, 0};
  logic [W-1:0] word   [2];
  bit           p_wrt  [2], p_rd[2], p_ack[2];
  logic [W-1:0] p_memo [2], p_data[2];
  int           cyc = 0;
  bit           use_dir;
  logic [W-1:0] dir_word;
  int           n_wr_obs[2] = '{0, 0};
  int           req_rate = 0;
  int           drop_rate = 0;

  always @(posedge clk) begin
    int cnt;
    bit rg, wg;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst_i) begin
        p_wrt[i] = 1'b0; p_rd[i] = 1'b0; p_ack[i] = 1'b0;
        p_memo[i] = '0;  p_data[i] = '0;
        rd_act[i] = 1'b0; rd_hold[i] = 1'b0;
        wr_idx[i] = exp_q.size();
      end else begin
        cnt = exp_q.size() - wr_idx[i];
        rg  = !rd_act[i] && rd_req[i] && (cnt < D - 1);
        wg  = !rg && (cnt > 0);
        p_rd[i]  = rg;
        p_wrt[i] = wg;
        p_ack[i] = 1'b0;
        if (wg) begin
          p_memo[i] = exp_q[wr_idx[i]];
          wr_idx[i]++;
        end
        if (rd_act[i] && rd_hold[i]) begin
          if (!rd_req[i]) rd_act[i] = 1'b0;
        end else if (rd_act[i] && cyc == tgt[i]) begin
          p_ack[i]   = 1'b1;
          p_data[i]  = word[i];
          rd_hold[i] = 1'b1;
        end
        if (rg) begin
          rd_act[i]  = 1'b1;
          rd_hold[i] = 1'b0;
          tgt[i]     = cyc + 1 + lat_of(i);
          word[i]    = use_dir ? dir_word : $urandom;
        end
      end
    end
    if (!rst_i && smpl_valid) exp_q.push_back(smpl);
  end

  // MMU model (data valid only in the cycle it is due) and random requester
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_act[i] && !rd_hold[i] && (cyc + 1 == tgt[i])) mem_i[i] = word[i];
      else mem_i[i] = $urandom;
      if (rd_ack[i] === 1'b1) auto_req[i] = 1'b0;
      else if (!auto_req[i]) begin
        if ($urandom_range(0, 99) < req_rate) auto_req[i] = 1'b1;
      end else if ($urandom_range(0, 99) < drop_rate) auto_req[i] = 1'b0;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    string s;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        s = (i == 0) ? "l1" : "l4";
        check({s, "_mem_wrt"},  W'(mem_wrt[i]),  W'(p_wrt[i]));
        check({s, "_mem_read"}, W'(mem_read[i]), W'(p_rd[i]));
        check({s, "_rd_ack"},   W'(rd_ack[i]),   W'(p_ack[i]));
        check({s, "_rd_data"},  rd_data[i],      p_data[i]);
        check({s, "_busy"},     W'(busy[i]),
              W'(((exp_q.size() - wr_idx[i]) > 0) || rd_act[i]));
        if (p_wrt[i]) check({s, "_mem_o"}, mem_o[i], p_memo[i]);
        if (mem_wrt[i] === 1'b1) n_wr_obs[i]++;
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    tick(2);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_mem_wrt",  W'(mem_wrt[i]),  '0);
      check("rst_mem_read", W'(mem_read[i]), '0);
      check("rst_rd_ack",   W'(rd_ack[i]),   '0);
      check("rst_rd_data",  rd_data[i],      '0);
      check("rst_mem_o",    mem_o[i],        '0);
      check("rst_busy",     W'(busy[i]),     '0);
    end
    rst_i = 1'b0;
  endtask

  task automatic wait_ack(input int i, input int budget, input string tag);
    int k = 0;
    while (rd_ack[i] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, W'(rd_ack[i]), W'(1));
  endtask

  initial begin
    int base0, base1;
    bit burst;
    rst_i = 1'b1; smpl_valid = 1'b0; smpl = '0; man_req = '0;
    req_mode = 1'b0; use_dir = 1'b0; dir_word = '0; burst = 1'b0;
    do_reset();

    // single write: strobe two edges after the sample edge
    @(negedge clk); smpl_valid = 1'b1; smpl = 32'hDEADBEEF;
    @(negedge clk); smpl_valid = 1'b0;
    check("sw_no_early", W'(mem_wrt[0]), '0);
    @(negedge clk);
    check("sw_wrt", W'(mem_wrt[0]), W'(1));
    check("sw_data", mem_o[0], 32'hDEADBEEF);
    check("sw_data_l4", mem_o[1], 32'hDEADBEEF);
    @(negedge clk);
    check("sw_wrt_done", W'(mem_wrt[0]), '0);
    check("sw_idle", W'(busy[0]), '0);

    // single read, RD_LAT=1, and no second read until the request drops
    use_dir = 1'b1; dir_word = 32'h12345678;
    @(negedge clk); man_req[0] = 1'b1;
    @(negedge clk); check("sr_strobe", W'(mem_read[0]), W'(1));
    @(negedge clk); check("sr_ack_early", W'(rd_ack[0]), '0);
    @(negedge clk);
    check("sr_ack", W'(rd_ack[0]), W'(1));
    check("sr_data", rd_data[0], 32'h12345678);
    repeat (3) begin
      @(negedge clk); check("sr_no_second", W'(mem_read[0]), '0);
    end
    man_req[0] = 1'b0;
    @(negedge clk); man_req[0] = 1'b1;
    @(negedge clk); check("sr_second", W'(mem_read[0]), W'(1));
    wait_ack(0, 8, "sr_second_ack");
    check("sr_second_data", rd_data[0], 32'h12345678);
    man_req[0] = 1'b0;
    tick(3);

    // contention: read wins the first decision, writes follow in order
    dir_word = 32'h5A5A0001;
    @(negedge clk); smpl_valid = 1'b1; smpl = 32'hA; man_req[0] = 1'b1;
    @(negedge clk); smpl = 32'hB;
    check("ct_read", W'(mem_read[0]), W'(1));
    check("ct_no_wr", W'(mem_wrt[0]), '0);
    @(negedge clk); smpl = 32'hC;
    check("ct_wr_a", W'(mem_wrt[0]), W'(1));
    check("ct_data_a", mem_o[0], 32'hA);
    check("ct_rd_off", W'(mem_read[0]), '0);
    @(negedge clk); smpl_valid = 1'b0;
    check("ct_data_b", mem_o[0], 32'hB);
    check("ct_ack", W'(rd_ack[0]), W'(1));
    check("ct_rd_data", rd_data[0], 32'h5A5A0001);
    man_req[0] = 1'b0;
    @(negedge clk);
    check("ct_wr_c", W'(mem_wrt[0]), W'(1));
    check("ct_data_c", mem_o[0], 32'hC);
    tick(3);

    // near-full priority: continuous burst with an eager requester
    use_dir = 1'b0;
    req_rate = 100; drop_rate = 0; req_mode = 1'b1;
    base0 = n_wr_obs[0]; base1 = n_wr_obs[1];
    for (int v = 0; v < 32; v++) begin
      @(negedge clk); smpl_valid = 1'b1; smpl = W'(v);
    end
    @(negedge clk); smpl_valid = 1'b0;
    tick(8);
    check("nf_writes_l1", W'(n_wr_obs[0] - base0), W'(32));
    check("nf_writes_l4", W'(n_wr_obs[1] - base1), W'(32));
    req_mode = 1'b0;
    tick(12);

    // reset in the middle of a RD_LAT=4 read with samples in flight
    @(negedge clk); man_req[1] = 1'b1; smpl_valid = 1'b1; smpl = $urandom;
    @(negedge clk); smpl = $urandom;
    check("rm_read", W'(mem_read[1]), W'(1));
    @(negedge clk); smpl = $urandom; rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0; smpl_valid = 1'b0; man_req[1] = 1'b0;
    check("rm_wrt0",  W'(mem_wrt[1]),  '0);
    check("rm_read0", W'(mem_read[1]), '0);
    check("rm_ack0",  W'(rd_ack[1]),   '0);
    check("rm_data0", rd_data[1],      '0);
    check("rm_memo0", mem_o[1],        '0);
    check("rm_busy0", W'(busy[1]),     '0);
    repeat (8) begin
      @(negedge clk);
      check("rm_no_ack", W'(rd_ack[1]), '0);
      check("rm_no_wr",  W'(mem_wrt[1]), '0);
    end
    use_dir = 1'b1; dir_word = 32'hCAFEF00D;
    @(negedge clk); man_req[1] = 1'b1;
    wait_ack(1, 12, "rm_fresh_ack");
    check("rm_fresh_data", rd_data[1], 32'hCAFEF00D);
    man_req[1] = 1'b0;
    tick(3);

    // random traffic with one reset pulse
    use_dir = 1'b0;
    req_rate = 25; drop_rate = 2; req_mode = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (c % 1000 == 0) burst = 1'($urandom_range(0, 1));
      smpl_valid = ($urandom_range(0, 99) < (burst ? 90 : 30));
      smpl = $urandom;
      rst_i = (c == 5123);
    end
    @(negedge clk); smpl_valid = 1'b0; rst_i = 1'b0; req_mode = 1'b0;
    tick(30);
    check("rnd_drained_l1", W'(busy[0]), '0);
    check("rnd_drained_l4", W'(busy[1]), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
